apb_cmd_sequencer: RTL

- Upstream stage of the APB master bridge. Buffers transfer commands from a user/DMA port in a command FIFO.
- Issues commands one at a time on the bridge's user-side request port (sel/addr/write/wdata/strb/prot/other_error).
- Collects each completion (ready/rdata/master_error) into a response FIFO, with a per-transfer timeout watchdog.

---
 rtl/apb_cmd_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/apb_cmd_sequencer.sv
// apb_cmd_sequencer: command FIFO -> one-at-a-time issue onto the bridge
// user port -> response FIFO, with a per-transfer watchdog.
module apb_cmd_sequencer #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int RSP_DEPTH      = 4,
  parameter int TIMEOUT        = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [APB_DATA_WIDTH/8-1:0]   cmd_strb,
  input  logic [2:0]                    cmd_prot,
  input  logic                          cmd_inj_err,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [APB_DATA_WIDTH-1:0]     rsp_rdata,
  output logic                          rsp_write,
  output logic                          rsp_error,
  output logic                          rsp_timeout,
  output logic                          m_sel,
  output logic                          m_write,
  output logic [APB_ADDR_WIDTH-1:0]     m_addr,
  output logic [APB_DATA_WIDTH-1:0]     m_wdata,
  output logic [APB_DATA_WIDTH/8-1:0]   m_strb,
  output logic [2:0]                    m_prot,
  output logic                          m_other_error,
  input  logic                          m_ready,
  input  logic [APB_DATA_WIDTH-1:0]     m_rdata,
  input  logic                          m_master_error,
  output logic                          busy
);
  localparam int SW  = APB_DATA_WIDTH/8;
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int TW  = $clog2(TIMEOUT+1);

  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]             strb;
    logic [2:0]                prot;
    logic                      inj_err;
  } cmd_t;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      write;
    logic                      error;
    logic                      timeout;
  } rsp_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t        state, state_nxt;
  cmd_t          cmd_mem [CMD_DEPTH];
  rsp_t          rsp_mem [RSP_DEPTH];
  logic [CAW:0]  cmd_wp, cmd_rp;
  logic [RAW:0]  rsp_wp, rsp_rp;
  logic [TW-1:0] wdog;
  cmd_t          cmd_in, cmd_head;
  rsp_t          rsp_in, rsp_head;
  logic          cmd_full, cmd_empty, rsp_full, rsp_empty;
  logic          cmd_push, cmd_pop, rsp_push, rsp_pop;

  // Extra MSB on each pointer separates full from empty.
  assign cmd_empty = (cmd_wp == cmd_rp);
  assign cmd_full  = (cmd_wp[CAW] != cmd_rp[CAW]) && (cmd_wp[CAW-1:0] == cmd_rp[CAW-1:0]);
  assign rsp_empty = (rsp_wp == rsp_rp);
  assign rsp_full  = (rsp_wp[RAW] != rsp_rp[RAW]) && (rsp_wp[RAW-1:0] == rsp_rp[RAW-1:0]);

  assign cmd_ready = ~cmd_full;
  assign cmd_push  = cmd_valid & ~cmd_full;
  assign rsp_valid = ~rsp_empty;
  assign rsp_pop   = rsp_valid & rsp_ready;
  assign busy      = (state != IDLE) | ~cmd_empty | ~rsp_empty;

  // Reads never carry strobes into the FIFO.
  assign cmd_in   = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata,
                      strb: cmd_write ? cmd_strb : '0, prot: cmd_prot, inj_err: cmd_inj_err};
  assign cmd_head = cmd_mem[cmd_rp[CAW-1:0]];
  assign rsp_head = rsp_mem[rsp_rp[RAW-1:0]];

  // Response head is shown only while valid so stale storage never leaks out.
  assign {rsp_rdata, rsp_write, rsp_error, rsp_timeout} = rsp_valid ? rsp_head : '0;

  // FIFO storage; no reset needed since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wp[CAW-1:0]] <= cmd_in;
    if (rsp_push) rsp_mem[rsp_wp[RAW-1:0]] <= rsp_in;
  end

  // FIFO pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_wp <= '0;
      cmd_rp <= '0;
      rsp_wp <= '0;
      rsp_rp <= '0;
    end else begin
      if (cmd_push) cmd_wp <= cmd_wp + (CAW+1)'(1);
      if (cmd_pop)  cmd_rp <= cmd_rp + (CAW+1)'(1);
      if (rsp_push) rsp_wp <= rsp_wp + (RAW+1)'(1);
      if (rsp_pop)  rsp_rp <= rsp_rp + (RAW+1)'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, issue and completion decisions. Issue waits for response
  // space so a completion always has a slot; m_ready beats the watchdog.
  always_comb begin
    state_nxt = state;
    cmd_pop   = 1'b0;
    rsp_push  = 1'b0;
    rsp_in    = '0;
    case (state)
      IDLE: if (!cmd_empty && !rsp_full) begin
        cmd_pop   = 1'b1;
        state_nxt = ACTIVE;
      end
      ACTIVE: if (m_ready) begin
        rsp_push      = 1'b1;
        rsp_in.rdata  = m_write ? '0 : m_rdata;
        rsp_in.write  = m_write;
        rsp_in.error  = m_master_error;
        state_nxt     = GAP;
      end else if (wdog == TW'(TIMEOUT-1)) begin
        rsp_push       = 1'b1;
        rsp_in.write   = m_write;
        rsp_in.timeout = 1'b1;
        state_nxt      = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request registers and watchdog; wdog holds the count of m_sel cycles already elapsed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_sel         <= 1'b0;
      m_write       <= 1'b0;
      m_addr        <= '0;
      m_wdata       <= '0;
      m_strb        <= '0;
      m_prot        <= '0;
      m_other_error <= 1'b0;
      wdog          <= '0;
    end else begin
      wdog <= (state == ACTIVE) ? wdog + TW'(1) : '0;
      if (cmd_pop) begin
        m_sel         <= 1'b1;
        m_write       <= cmd_head.write;
        m_addr        <= cmd_head.addr;
        m_wdata       <= cmd_head.wdata;
        m_strb        <= cmd_head.strb;
        m_prot        <= cmd_head.prot;
        m_other_error <= cmd_head.inj_err;
      end else if (rsp_push) begin
        m_sel <= 1'b0;
      end
    end
  end
endmodule
